sweep_ctrl: RTL and testbench
=============================

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning the counter and bound width.
REQ-002 SHALL have parameter R, default 4, meaning the repeat-count width.
REQ-003 SHALL have port clk, input, 1 bit: the clock.
REQ-004 SHALL have port reset, input, 1 bit: the reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: begin a sweep; honoured only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: terminate any activity and clear the count.
REQ-007 SHALL have port pause, input, 1 bit: freeze stepping while in UP or DOWN.
REQ-008 SHALL have port lo, input, N bits: lower sweep bound.
REQ-009 SHALL have port hi, input, N bits: upper sweep bound.
REQ-010 SHALL have port reps, input, R bits: number of up/down round trips.
REQ-011 SHALL have port q, output, N bits: current count value.
REQ-012 SHALL have port busy, output, 1 bit: high in LOAD, UP, DOWN and DONE.
REQ-013 SHALL have port dir, output, 1 bit: 1 in UP, 0 otherwise.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse on a rejected start.
REQ-016 SHALL have port reps_left, output, R bits: round trips remaining, including the current one.

Function
REQ-017 SHALL implement an FSM with states IDLE, LOAD, UP, DOWN and DONE.
REQ-018 In IDLE, start with lo<hi and reps!=0 SHALL latch lo, hi and reps, then go to LOAD; bounds are used only from the latch afterwards.
REQ-019 In IDLE, start with lo>=hi or reps==0 SHALL pulse err the next cycle, stay in IDLE and leave q unchanged.
REQ-020 LOAD SHALL load the counter with lo (q=lo after the edge), then go to UP.
REQ-021 UP with q!=hi SHALL increment q by 1.
REQ-022 UP with q==hi SHALL decrement q by 1 in the same cycle and go to DOWN.
REQ-023 DOWN with q!=lo SHALL decrement q by 1.
REQ-024 DOWN with q==lo and reps_left>1 SHALL decrement reps_left, increment q and go to UP.
REQ-025 DOWN with q==lo and reps_left==1 SHALL go to DONE with no step.
REQ-026 DONE SHALL last one cycle with done=1, then go to IDLE; q holds lo.
REQ-027 Sweep latency SHALL be 1 + 2*(hi-lo)*reps + 1 + 1 cycles of busy, from the cycle after start acceptance to the end of DONE, excluding paused cycles.
REQ-028 While pause=1 in UP or DOWN, the state, q and reps_left SHALL hold; pause SHALL be ignored in other states.
REQ-029 abort SHALL have the highest priority in any state: synchronously clear q to 0, go to IDLE and clear reps_left, with no done or err pulse.
REQ-030 Simultaneous abort and start in IDLE SHALL clear q and reject start silently (no err).
REQ-031 start SHALL be ignored while busy=1.
REQ-032 q SHALL never wrap: hi=2**N-1 and lo=0 are legal and are the turnaround points.

Reset
REQ-033 reset SHALL force IDLE, q=0, reps_left=0, busy=0, dir=0, done=0 and err=0 immediately.
REQ-034 Reset mid-sweep SHALL discard the latched bounds; the first sweep after release requires a new start.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding constants (IDLE, LOAD, UP, DOWN, DONE).
REQ-036 The datapath SHALL be a single instance of sub-module univ_bin_counter (width N).
REQ-037 The FSM SHALL drive the counter's syn_clear, load, d, en and up inputs.
REQ-038 q SHALL be the counter's q output.

Verification
REQ-039 Basic sweep: N=8, lo=2, hi=5, reps=1, start -> q sequence 2,3,4,5,4,3,2; busy high for 9 cycles; done pulses once; dir=1 only during the climb.
REQ-040 Repeats: lo=0, hi=2, reps=3 -> q sequence 0,1,2,1,0,1,2,1,0,1,2,1,0; reps_left steps 3,2,1; done once.
REQ-041 Rejects: start with lo=5, hi=5, then with reps=0 -> err pulses once each; state stays IDLE; q unchanged.
REQ-042 Full range: lo=0, hi=255, reps=1 -> q reaches 255 with no wrap to 0, turns, returns to 0; busy lasts 513 cycles.
REQ-043 Pause and abort: pause for 4 cycles at q=3 in UP -> q holds 3, then resumes 4; abort at q=4 -> q=0 next cycle, IDLE, no done.
REQ-044 Reset mid-DOWN -> immediately all outputs 0 and IDLE; a later start sweeps normally.

Source files
------------

// File: rtl/sweep_ctrl_pkg.sv
// ============================================================================
// sweep_ctrl_pkg : shared FSM state encoding for the sweep controller
// Revision       : 1.0
// ============================================================================
`default_nettype none

package sweep_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sweep_ctrl_counter.sv
// ============================================================================
// univ_bin_counter : up/down binary counter with sync clear, load and enable
// Revision         : 1.0
// ============================================================================
`default_nettype none

module univ_bin_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clear,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    // Priority: clear over load over counting.
    always_comb begin
        q_d = q_q;
        if (syn_clear) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end else if (en) begin
            q_d = up ? (q_q + ONE) : (q_q - ONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/sweep_ctrl.sv
// ============================================================================
// sweep_ctrl : triangular lo->hi->lo sweep generator with repeat, pause, abort
// Revision   : 1.0
// ============================================================================
`default_nettype none

module sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic         pause,
    input  logic [N-1:0] lo,
    input  logic [N-1:0] hi,
    input  logic [R-1:0] reps,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         dir,
    output logic         done,
    output logic         err,
    output logic [R-1:0] reps_left
);

    localparam logic [R-1:0] REPS_ONE = {{(R-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] lo_q, lo_d;
    logic [N-1:0] hi_q, hi_d;
    logic [R-1:0] reps_left_q, reps_left_d;
    logic         err_q, err_d;

    logic         cnt_clear;
    logic         cnt_load;
    logic         cnt_en;
    logic         cnt_up;
    logic [N-1:0] cnt_q;

    univ_bin_counter #(
        .N(N)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .syn_clear(cnt_clear),
        .load     (cnt_load),
        .en       (cnt_en),
        .up       (cnt_up),
        .d        (lo_q),
        .q        (cnt_q)
    );

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        reps_left_d = reps_left_q;
        err_d       = 1'b0;
        cnt_clear   = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_up      = 1'b0;

        if (abort) begin
            // Abort wins everywhere, including over a coincident start.
            state_d     = ST_IDLE;
            reps_left_d = '0;
            cnt_clear   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if ((lo < hi) && (reps != '0)) begin
                            lo_d        = lo;
                            hi_d        = hi;
                            reps_left_d = reps;
                            state_d     = ST_LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    cnt_load = 1'b1;
                    state_d  = ST_UP;
                end
                ST_UP: begin
                    if (!pause) begin
                        cnt_en = 1'b1;
                        if (cnt_q != hi_q) begin
                            cnt_up = 1'b1;
                        end else begin
                            // Turn around on the peak without an idle cycle.
                            state_d = ST_DOWN;
                        end
                    end
                end
                ST_DOWN: begin
                    if (!pause) begin
                        if (cnt_q != lo_q) begin
                            cnt_en = 1'b1;
                        end else if (reps_left_q != REPS_ONE) begin
                            cnt_en      = 1'b1;
                            cnt_up      = 1'b1;
                            reps_left_d = reps_left_q - REPS_ONE;
                            state_d     = ST_UP;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            reps_left_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            reps_left_q <= reps_left_d;
            err_q       <= err_d;
        end
    end

    assign q         = cnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign dir       = (state_q == ST_UP);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign reps_left = reps_left_q;

endmodule

`default_nettype wire

// File: tb/tb_sweep_ctrl.sv
// ============================================================================
// tb_sweep_ctrl : self-checking bench for sweep_ctrl against a trace model
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_sweep_ctrl;

    localparam int N = 8;
    localparam int R = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic         pause;
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic [R-1:0] reps;
    logic [N-1:0] q;
    logic         busy;
    logic         dir;
    logic         done;
    logic         err;
    logic [R-1:0] reps_left;

    int checks = 0;
    int errors = 0;
    int idle_q = 0;

    // One entry per non-paused busy cycle of a sweep.
    typedef struct {
        int q;
        bit dir;
        bit done;
        int rl;
        bit pausable;
        bit chkq;
    } exp_t;

    exp_t exp_q[$];

    sweep_ctrl #(.N(N), .R(R)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .pause    (pause),
        .lo       (lo),
        .hi       (hi),
        .reps     (reps),
        .q        (q),
        .busy     (busy),
        .dir      (dir),
        .done     (done),
        .err      (err),
        .reps_left(reps_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic build_trace(input int l, input int h, input int r);
        exp_t e;
        exp_q.delete();
        e = '{q: 0, dir: 0, done: 0, rl: r, pausable: 0, chkq: 0};
        exp_q.push_back(e);
        for (int t = 0; t < r; t++) begin
            for (int v = (t == 0) ? l : l + 1; v <= h; v++) begin
                e = '{q: v, dir: 1, done: 0, rl: r - t, pausable: 1, chkq: 1};
                exp_q.push_back(e);
            end
            for (int v = h - 1; v >= l; v--) begin
                e = '{q: v, dir: 0, done: 0, rl: r - t, pausable: 1, chkq: 1};
                exp_q.push_back(e);
            end
        end
        e = '{q: l, dir: 0, done: 1, rl: 1, pausable: 0, chkq: 1};
        exp_q.push_back(e);
    endtask

    // Entered and left just after a falling edge.
    task automatic run_sweep(input int l, input int h, input int r, input int pause_pct);
        exp_t e;
        int   idx;
        int   guard;
        int   busy_obs;
        bit   p;
        build_trace(l, h, r);
        lo    = l[N-1:0];
        hi    = h[N-1:0];
        reps  = r[R-1:0];
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        idx      = 0;
        guard    = 0;
        busy_obs = 0;
        while (idx < exp_q.size() && guard < 4 * exp_q.size() + 20) begin
            e = exp_q[idx];
            chk("sweep_busy", busy, 1);
            chk("sweep_dir", dir, e.dir);
            chk("sweep_done", done, e.done);
            chk("sweep_reps_left", reps_left, e.rl);
            chk("sweep_err", err, 0);
            if (e.chkq) chk("sweep_q", q, e.q);
            p     = ($urandom_range(99) < pause_pct);
            pause = p;
            if (idx < exp_q.size() - 1) begin
                start = $urandom_range(1);
                lo    = $urandom;
                hi    = $urandom;
                reps  = $urandom;
            end else begin
                start = 1'b0;
            end
            if (!(p && e.pausable)) begin
                idx++;
                if (busy) busy_obs++;
            end
            guard++;
            @(negedge clk);
        end
        pause = 1'b0;
        start = 1'b0;
        chk("sweep_complete", idx, exp_q.size());
        chk("busy_cycles", busy_obs, 1 + 2 * (h - l) * r + 2);
        chk("end_busy", busy, 0);
        chk("end_done", done, 0);
        chk("end_dir", dir, 0);
        chk("end_q", q, l);
        idle_q = l;
    endtask

    task automatic reject(input int l, input int h, input int r);
        lo    = l[N-1:0];
        hi    = h[N-1:0];
        reps  = r[R-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reject_err", err, 1);
        chk("reject_busy", busy, 0);
        chk("reject_q", q, idle_q);
        @(negedge clk);
        chk("reject_err_clear", err, 0);
        chk("reject_idle", busy, 0);
        chk("reject_q_hold", q, idle_q);
    endtask

    initial begin
        int g;
        int l;
        int h;
        int r;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        lo    = '0;
        hi    = '0;
        reps  = '0;

        @(negedge clk);
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dir", dir, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_reps_left", reps_left, 0);
        reset = 1'b0;
        @(negedge clk);

        run_sweep(2, 5, 1, 0);
        reject(5, 5, 1);
        reject(1, 9, 0);
        reject(7, 3, 2);

        // Abort together with a valid start in IDLE: clear, no err, no sweep.
        lo    = 8'd1;
        hi    = 8'd9;
        reps  = 4'd1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_q", q, 0);
        chk("abort_start_err", err, 0);
        chk("abort_start_busy", busy, 0);
        @(negedge clk);
        chk("abort_start_idle", busy, 0);
        chk("abort_start_err2", err, 0);
        idle_q = 0;

        run_sweep(0, 2, 3, 0);
        run_sweep(0, 255, 1, 0);
        run_sweep(250, 255, 2, 20);
        run_sweep(0, 1, 15, 10);

        for (int i = 0; i < 6; i++) begin
            l = $urandom_range(0, 200);
            h = l + $urandom_range(1, 12);
            r = $urandom_range(1, 3);
            run_sweep(l, h, r, 20);
        end

        // Pause in UP at q=3, then abort on the next step.
        lo    = 8'd1;
        hi    = 8'd8;
        reps  = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g     = 0;
        while (!(dir && q == 8'd3) && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("reach_q3", q, 3);
        pause = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("pause_q", q, 3);
            chk("pause_dir", dir, 1);
        end
        pause = 1'b0;
        @(negedge clk);
        chk("resume_q", q, 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_q", q, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_reps_left", reps_left, 0);
        chk("abort_err", err, 0);
        @(negedge clk);
        chk("abort_no_done", done, 0);
        chk("abort_stay_idle", busy, 0);
        idle_q = 0;

        // Asynchronous reset while descending.
        lo    = 8'd0;
        hi    = 8'd6;
        reps  = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g     = 0;
        while (!(busy && !dir && q == 8'd4) && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("mid_down_reached", (busy && !dir && q == 8'd4), 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_q", q, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_dir", dir, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        chk("midrst_reps_left", reps_left, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", busy, 0);
            chk("post_rst_q", q, 0);
        end
        idle_q = 0;
        run_sweep(3, 7, 2, 25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
